alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Microprogram sequencer sitting directly upstream of the 8-bit register/ALU datapath. It holds a small loadable program of datapath micro-instructions, steps through it on `start`, and drives the datapath control inputs (`data_in`, `reg_sel`, `alu_op`, `write_en`, `alu_en`, `cin`) one instruction at a time. It captures the datapath's `data_out` and status flags back into result and flag registers, and signals completion with a one-cycle `done`.

## Interface
- `WIDTH`, 8: datapath width.
- `DEPTH`, 16: program memory entries (power of 2); `AW = $clog2(DEPTH)`.
- Instruction width `IW = WIDTH+8`, derived: `{kind[1:0], reg_sel[1:0], alu_op[2:0], cin, imm[WIDTH-1:0]}` from MSB down.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  AW  program write address.
- `prog_data`  in  IW  program write data.
- `start`  in  1  run program from address 0.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  last value captured by a READ.
- `zero_q` / `neg_q` / `ovf_q`  out  1 each  flags captured on the last EXEC.
- `ovf_sticky`  out  1  OR of `ovf` over all EXECs of the current run.
- `dp_data_in`  out  WIDTH  to datapath `data_in`.
- `dp_reg_sel`  out  2  to datapath `reg_sel`.
- `dp_alu_op`  out  3  to datapath `alu_op`.
- `dp_write_en`  out  1  to datapath `write_en`.
- `dp_alu_en`  out  1  to datapath `alu_en`.
- `dp_cin`  out  1  to datapath `cin`.
- `dp_data_out`  in  WIDTH  from datapath `data_out`.
- `dp_zero` / `dp_neg` / `dp_ovf`  in  1 each  from datapath flags.

## Operation
- Instruction kinds:
  - `00` LOAD: write `imm` into `reg_sel` (`write_en=1`, `alu_en=0`, `data_in=imm`).
  - `01` EXEC: write ALU(`a=imm`, `b=reg C`) into `reg_sel` (`write_en=1`, `alu_en=1`, `alu_op`, `cin` from the word).
  - `10` READ: `write_en=0`, `reg_sel` driven, `result <= dp_data_out`.
  - `11` HALT.
- `reg_sel=11` is passed through unchanged; the datapath ignores it, and no error is raised.
- FSM states are IDLE, FETCH, ISSUE, DONE.
  - IDLE: on `start=1`, clear `pc`, clear `ovf_sticky`, go to FETCH.
  - FETCH: `ir <= mem[pc]`, go to ISSUE.
  - ISSUE: drive `dp_*` from `ir` for exactly this cycle.
    - On HALT, go to DONE.
    - Otherwise, if `pc==DEPTH-1`, go to DONE (implicit halt, no wrap).
    - Otherwise, `pc <= pc+1` and go to FETCH.
  - DONE: `done=1`, go to IDLE.
- EXEC in ISSUE: `zero_q/neg_q/ovf_q <= dp_zero/dp_neg/dp_ovf`, and `ovf_sticky <= ovf_sticky | dp_ovf`.
- Outside ISSUE, and in ISSUE for HALT, all `dp_*` outputs are 0. `dp_write_en` is never high outside ISSUE.
- `prog_we` is honoured only in IDLE; it is ignored while `busy`.
- `start` while `busy` is ignored. `start` and `prog_we` together in IDLE: the write completes and the run starts; address 0 reads the new word.
- `result` and the flag registers hold their values between runs; only `ovf_sticky` is cleared by `start`.

## Timing
- Reset values: state IDLE, `pc=0`, `ir=0`, `busy=0`, `done=0`, `result=0`, all flags 0, all `dp_*` 0. Program memory is not reset.
- Each instruction takes 2 cycles. With `start` sampled at edge E0, instruction i is in FETCH during cycle 2i+1 and in ISSUE during cycle 2i+2.
- If HALT is at index k, `done` is high during cycle 2k+3 and `busy` falls in cycle 2k+4.
- Datapath writes land at the edge ending the ISSUE cycle. A READ immediately after a write sees the new value, because at least one FETCH cycle separates them.
- READ captures the combinational `dp_data_out` at the edge ending ISSUE. EXEC flags are captured at the same edge.
- `rst_n` asserted mid-run returns all state to reset values immediately (`dp_write_en` drops asynchronously). No `done` is produced.

## Test plan
- Program {LOAD C=5; EXEC A = 3+C, op 000; READ A; HALT}, start → `result=8`, `zero_q=0`, `done` in cycle 9 exactly once, `dp_write_en` high in cycles 2 and 4 only.
- Program {LOAD C=0x01; EXEC B = 0x7F+C, op 000; READ B; HALT} → `result=0x80`, `neg_q=1`, `ovf_q=1`, `ovf_sticky=1`.
- Program of 16 LOADs with no HALT → implicit halt after index 15, `done` in cycle 33, `pc` does not wrap.
- Pulse `start` and `prog_we` during a run → no restart, memory unchanged, `done` timing unaffected.
- Assert `rst_n=0` during the ISSUE of an EXEC → all outputs 0 immediately, no `done`. A new run after release behaves normally.
- HALT at address 0 → `done` in cycle 3, no `dp_write_en` activity, `result` unchanged.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - microprogram sequencer driving the 8-bit register/ALU datapath
// Fetches one micro-instruction per two cycles and captures READ data and EXEC flags.
module alu_seq_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = WIDTH + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_q,
  output logic             neg_q,
  output logic             ovf_q,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] dp_data_in,
  output logic [1:0]       dp_reg_sel,
  output logic [2:0]       dp_alu_op,
  output logic             dp_write_en,
  output logic             dp_alu_en,
  output logic             dp_cin,
  input  logic [WIDTH-1:0] dp_data_out,
  input  logic             dp_zero,
  input  logic             dp_neg,
  input  logic             dp_ovf
);

  localparam logic [1:0] K_LOAD = 2'b00;
  localparam logic [1:0] K_EXEC = 2'b01;
  localparam logic [1:0] K_READ = 2'b10;
  localparam logic [1:0] K_HALT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic [IW-1:0] mem [DEPTH];
  logic [1:0]    ir_kind;
  logic          issue;

  assign ir_kind = ir[IW-1 -: 2];
  assign issue   = (state == S_ISSUE);

  // Datapath controls decode straight from state and ir, so an async reset
  // (state -> IDLE) removes write_en without waiting for a clock edge.
  assign dp_write_en = issue && (ir_kind == K_LOAD || ir_kind == K_EXEC);
  assign dp_alu_en   = issue && (ir_kind == K_EXEC);
  assign dp_data_in  = dp_write_en ? ir[WIDTH-1:0] : '0;
  assign dp_reg_sel  = (issue && ir_kind != K_HALT) ? ir[IW-3 -: 2] : 2'b00;
  assign dp_alu_op   = dp_alu_en ? ir[IW-5 -: 3] : 3'b000;
  assign dp_cin      = dp_alu_en && ir[WIDTH];

  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (ir_kind == K_EXEC) begin
            zero_q     <= dp_zero;
            neg_q      <= dp_neg;
            ovf_q      <= dp_ovf;
            ovf_sticky <= ovf_sticky | dp_ovf;
          end
          if (ir_kind == K_READ) begin
            result <= dp_data_out;
          end
          // Last slot acts as an implicit HALT; pc never wraps to 0.
          if (ir_kind == K_HALT || pc == AW'(DEPTH - 1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
